// File: rtl/bl_sdbp_tx.sv
// -----------------------------------------------------------------------------
// bl_sdbp_tx
//
// Backlight zone transmitter. Captures per-zone 16-bit backlight values from
// the gray-max stage into a ping-pong zone buffer. On each rising edge of
// sdbpflag it swaps banks and shifts the completed frame (a header word
// followed by every zone, clamped to MAX_DUTY) out over a mode-0 SPI link.
//
// Ports:
//   clk        system clock (single domain)
//   rst_n      asynchronous active-low reset
//   wtwe       zone write strobe
//   wtaddr     zone index, 0..NUM_ZONES-1 (others ignored)
//   wtdina     zone value
//   sdbpflag   frame-send request, rising edge only
//   spi_sclk   serial clock, idle low
//   spi_mosi   serial data, MSB first, changes only while spi_sclk is low
//   spi_cs_n   chip select, active low
//   busy       high from LOAD until the end of the inter-frame gap
//   frame_done one-cycle pulse when the gap completes
//   drop_cnt   requests seen while busy, saturating at 255
// -----------------------------------------------------------------------------
module bl_sdbp_tx #(
    parameter int          NUM_ZONES = 360,
    parameter int          CLK_DIV   = 2,
    parameter logic [15:0] CMD_WORD  = 16'h5A01,
    parameter logic [15:0] MAX_DUTY  = 16'hFFF0,
    parameter int          CS_GAP    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wtwe,
    input  logic [9:0]  wtaddr,
    input  logic [15:0] wtdina,
    input  logic        sdbpflag,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    localparam int AW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int IW = $clog2(NUM_ZONES + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(CLK_DIV + CS_GAP + 1);

    localparam logic [DW-1:0] DIV_LAST      = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_HOLD_LAST = GW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST      = GW'(CLK_DIV + CS_GAP - 1);
    localparam logic [IW-1:0] ZONES_I       = IW'(NUM_ZONES);
    localparam logic [9:0]    ZONES_A       = 10'(NUM_ZONES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t         state_reg,      state_next;
    logic           flag_d_reg,     flag_d_next;
    logic           armed_reg,      armed_next;
    logic           wr_bank_reg,    wr_bank_next;
    logic [7:0]     drop_cnt_reg,   drop_cnt_next;
    logic [15:0]    shreg_reg,      shreg_next;
    logic [3:0]     bit_cnt_reg,    bit_cnt_next;
    logic [DW-1:0]  div_cnt_reg,    div_cnt_next;
    logic [GW-1:0]  gap_cnt_reg,    gap_cnt_next;
    logic [IW-1:0]  word_idx_reg,   word_idx_next;
    logic [AW-1:0]  rd_idx_reg,     rd_idx_next;
    logic           cs_n_reg,       cs_n_next;
    logic           sclk_reg,       sclk_next;
    logic           mosi_reg,       mosi_next;
    logic           frame_done_reg, frame_done_next;

    logic           req;
    logic           wr_en;
    logic [AW-1:0]  wr_idx;
    logic [15:0]    rd_data;
    logic [15:0]    clamp_word;
    logic [IW-1:0]  word_inc;

    // armed_reg stays low after reset until sdbpflag has been seen low, so a
    // level that is already high when reset releases does not count as an edge.
    assign req    = sdbpflag & ~flag_d_reg & armed_reg;
    assign wr_en  = wtwe && (wtaddr < ZONES_A);
    assign wr_idx = wtaddr[AW-1:0];

    // Ping-pong zone buffer. Bank gi takes writes while wr_bank_reg == gi;
    // the transmitter reads the other bank with one cycle of read latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [15:0] mem [NUM_ZONES];
        logic [15:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank_reg == 1'(gi))) begin
                mem[wr_idx] <= wtdina;
            end
            rd_q <= mem[rd_idx_reg];
        end
    end

    assign rd_data    = wr_bank_reg ? g_bank[0].rd_q : g_bank[1].rd_q;
    assign clamp_word = (rd_data > MAX_DUTY) ? MAX_DUTY : rd_data;
    assign word_inc   = word_idx_reg + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            flag_d_reg     <= 1'b0;
            armed_reg      <= 1'b0;
            wr_bank_reg    <= 1'b0;
            drop_cnt_reg   <= 8'd0;
            shreg_reg      <= 16'd0;
            bit_cnt_reg    <= 4'd0;
            div_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            word_idx_reg   <= '0;
            rd_idx_reg     <= '0;
            cs_n_reg       <= 1'b1;
            sclk_reg       <= 1'b0;
            mosi_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flag_d_reg     <= flag_d_next;
            armed_reg      <= armed_next;
            wr_bank_reg    <= wr_bank_next;
            drop_cnt_reg   <= drop_cnt_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            div_cnt_reg    <= div_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            word_idx_reg   <= word_idx_next;
            rd_idx_reg     <= rd_idx_next;
            cs_n_reg       <= cs_n_next;
            sclk_reg       <= sclk_next;
            mosi_reg       <= mosi_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        flag_d_next     = sdbpflag;
        armed_next      = armed_reg | ~sdbpflag;
        wr_bank_next    = wr_bank_reg;
        drop_cnt_next   = drop_cnt_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        div_cnt_next    = div_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        word_idx_next   = word_idx_reg;
        rd_idx_next     = rd_idx_reg;
        cs_n_next       = cs_n_reg;
        sclk_next       = sclk_reg;
        mosi_next       = mosi_reg;
        frame_done_next = 1'b0;

        // Requests during an active frame are only counted.
        if (req && (state_reg != ST_IDLE) && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    wr_bank_next = ~wr_bank_reg;
                    state_next   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cs_n_next     = 1'b0;
                sclk_next     = 1'b0;
                shreg_next    = CMD_WORD;
                mosi_next     = CMD_WORD[15];
                bit_cnt_next  = 4'd15;
                div_cnt_next  = '0;
                word_idx_next = '0;
                rd_idx_next   = '0;
                state_next    = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        // End of a bit: falling SCLK, MOSI advances here only.
                        sclk_next = 1'b0;
                        if (bit_cnt_reg != 4'd0) begin
                            bit_cnt_next = bit_cnt_reg - 4'd1;
                            shreg_next   = {shreg_reg[14:0], 1'b0};
                            mosi_next    = shreg_reg[14];
                        end else if (word_idx_reg < ZONES_I) begin
                            // rd_data holds zone word_idx_reg, prefetched a
                            // full word earlier; fetch the following zone now.
                            shreg_next    = clamp_word;
                            mosi_next     = clamp_word[15];
                            bit_cnt_next  = 4'd15;
                            word_idx_next = word_inc;
                            if (word_inc < ZONES_I) begin
                                rd_idx_next = AW'(word_inc);
                            end
                        end else begin
                            mosi_next    = 1'b0;
                            gap_cnt_next = '0;
                            state_next   = ST_GAP;
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DW'(1);
                end
            end

            ST_GAP: begin
                // CS held low for CLK_DIV cycles, then high for CS_GAP cycles.
                sclk_next = 1'b0;
                mosi_next = 1'b0;
                cs_n_next = (gap_cnt_reg >= GAP_HOLD_LAST);
                if (gap_cnt_reg == GAP_LAST) begin
                    frame_done_next = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign spi_sclk   = sclk_reg;
    assign spi_mosi   = mosi_reg;
    assign spi_cs_n   = cs_n_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_bl_sdbp_tx.sv
// -----------------------------------------------------------------------------
// tb_bl_sdbp_tx
//
// Scoreboard bench for bl_sdbp_tx. Every accepted request pushes the frame the
// transmitter should send (header plus clamped zones from a bench-side model
// of the ping-pong buffer) onto a queue; a SPI receiver pops and compares each
// word. Frame length, gap timing, drop counting and reset behaviour are also
// checked.
// -----------------------------------------------------------------------------
module tb_bl_sdbp_tx;

    localparam int NZ        = 360;
    localparam int CS_GAP    = 8;
    localparam int FRAME_CYC = 16 * (NZ + 1) * 2 * 2 + 2;   // 23106

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wtwe     = 1'b0;
    logic [9:0]  wtaddr   = 10'd0;
    logic [15:0] wtdina   = 16'd0;
    logic        sdbpflag = 1'b0;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    bl_sdbp_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wtwe       (wtwe),
        .wtaddr     (wtaddr),
        .wtdina     (wtdina),
        .sdbpflag   (sdbpflag),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [15:0] model_mem [2][NZ];
    logic        m_wr     = 1'b0;
    logic [15:0] exp_q [$];
    int          exp_drop = 0;

    function automatic logic [15:0] clampf(input logic [15:0] v);
        return (v > 16'hFFF0) ? 16'hFFF0 : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame_model();
        logic rb;
        rb   = m_wr;
        m_wr = ~m_wr;
        exp_q.push_back(16'h5A01);
        for (int i = 0; i < NZ; i++) exp_q.push_back(clampf(model_mem[rb][i]));
    endtask

    task automatic write_zone(input logic [9:0] a, input logic [15:0] d);
        wtwe   = 1'b1;
        wtaddr = a;
        wtdina = d;
        if (a < 10'(NZ)) model_mem[m_wr][a] = d;
        tick(1);
        wtwe = 1'b0;
    endtask

    task automatic pulse_req(input bit start);
        sdbpflag = 1'b1;
        if (start) start_frame_model();
        else if (exp_drop < 255) exp_drop++;
        tick(1);
        sdbpflag = 1'b0;
        tick(1);
    endtask

    // ---------------- SPI receiver / monitor ----------------
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_mosi = 1'b0;
    logic [15:0] rx_sh     = 16'd0;
    logic [15:0] exp_w;
    int rx_bits = 0, frame_bits = 0, rx_words = 0, cs_len = 0;
    int cs_falls = 0, done_cnt = 0, since_rise = 0;
    bit counting = 1'b0, in_frame = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            in_frame   = 1'b0;
            counting   = 1'b0;
            rx_bits    = 0;
            frame_bits = 0;
            prev_sclk  = 1'b0;
            prev_cs    = 1'b1;
            prev_mosi  = 1'b0;
        end else begin
            if (counting) since_rise++;
            if (prev_cs && !spi_cs_n) begin
                in_frame   = 1'b1;
                cs_len     = 0;
                rx_words   = 0;
                rx_bits    = 0;
                frame_bits = 0;
                cs_falls++;
            end
            if (!spi_cs_n) cs_len++;
            if (!spi_cs_n && prev_sclk && spi_sclk && (spi_mosi !== prev_mosi))
                chk("mosi_stable_while_sclk_high", 32'd1, 32'd0);
            if (!spi_cs_n && spi_sclk && !prev_sclk) begin
                rx_sh = {rx_sh[14:0], spi_mosi};
                rx_bits++;
                frame_bits++;
                if (rx_bits == 16) begin
                    rx_bits = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        chk($sformatf("f%0d_word%0d", cs_falls, rx_words), rx_sh, exp_w);
                    end
                    rx_words++;
                end
            end
            if (!prev_cs && spi_cs_n && in_frame) begin
                in_frame = 1'b0;
                chk("cs_low_cycles", cs_len, FRAME_CYC);
                chk("frame_words", rx_words, NZ + 1);
                chk("frame_tail_bits", rx_bits, 0);
                since_rise = 0;
                counting   = 1'b1;
                $display("frame %0d received: %0d words, cs low %0d cycles", cs_falls, rx_words, cs_len);
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_after_cs_rise", since_rise, CS_GAP);
                chk("busy_at_done", busy, 0);
                counting = 1'b0;
            end
            prev_sclk = spi_sclk;
            prev_cs   = spi_cs_n;
            prev_mosi = spi_mosi;
        end
    end

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            tick(1);
            n++;
        end
        chk("frame_done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int falls_before;

        tick(3);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // Frame 1: ramp data, out-of-range writes ignored, held flag = one frame.
        for (int i = 0; i < NZ; i++) write_zone(10'(i), 16'h0100 + 16'(i));
        write_zone(10'd360, 16'hDEAD);
        write_zone(10'd1023, 16'hBEEF);
        sdbpflag = 1'b1;
        start_frame_model();
        $display("request: frame 1 (flag held 100 cycles)");
        tick(1);
        chk("load_busy", busy, 1);
        chk("load_cs_n", spi_cs_n, 1);
        tick(1);
        chk("start_cs_n", spi_cs_n, 0);
        chk("start_mosi_msb", spi_mosi, 0);
        chk("start_sclk", spi_sclk, 0);
        tick(98);
        sdbpflag = 1'b0;
        tick(2);

        // Three requests while busy are dropped.
        for (int i = 0; i < 3; i++) begin
            pulse_req(1'b0);
            $display("request while busy: drop %0d", exp_drop);
        end
        chk("drop_cnt_3", drop_cnt, exp_drop);

        // Fill the other bank during frame 1 (clamp cases at zones 5..7).
        for (int i = 0; i < NZ; i++)
            write_zone(10'(i), (i == 5) ? 16'hFFFF : (i == 6) ? 16'hFFF0 :
                               (i == 7) ? 16'h0000 : 16'h2222);
        wait_done(1, FRAME_CYC + 200);
        chk("frames_started_f1", cs_falls, 1);
        chk("drop_cnt_after_f1", drop_cnt, 3);

        // Frame 2: ping-pong bank, then 300 drops to saturate.
        $display("request: frame 2");
        pulse_req(1'b1);
        for (int i = 0; i < 300; i++) pulse_req(1'b0);
        $display("300 requests while busy issued");
        chk("drop_cnt_sat", drop_cnt, exp_drop);
        for (int i = 0; i < NZ; i++) write_zone(10'(i), 16'h1111);

        // Reset at bit 800 of frame 2.
        n = 0;
        while (frame_bits < 800 && n < 5000) begin
            tick(1);
            n++;
        end
        chk("reach_bit800", 32'(frame_bits >= 800), 32'd1);
        rst_n    = 1'b0;
        sdbpflag = 1'b1;
        m_wr     = 1'b0;
        exp_drop = 0;
        #1;
        $display("reset asserted mid-frame");
        chk("midrst_cs_n", spi_cs_n, 1);
        chk("midrst_sclk", spi_sclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        falls_before = cs_falls;
        tick(50);
        chk("no_start_on_held_level", cs_falls, falls_before);
        chk("idle_after_rst_busy", busy, 0);
        sdbpflag = 1'b0;
        tick(2);

        // Frame 3: write and request in the same cycle.
        wtwe   = 1'b1;
        wtaddr = 10'd10;
        wtdina = 16'h0ABC;
        model_mem[m_wr][10] = 16'h0ABC;
        sdbpflag = 1'b1;
        start_frame_model();
        $display("request: frame 3 with same-cycle write to zone 10");
        tick(1);
        wtwe     = 1'b0;
        sdbpflag = 1'b0;
        tick(1);
        wait_done(2, FRAME_CYC + 200);
        tick(5);

        chk("queue_empty", exp_q.size(), 0);
        chk("total_cs_falls", cs_falls, 3);
        chk("total_frame_done", done_cnt, 2);
        chk("final_drop_cnt", drop_cnt, 0);
        chk("final_cs_n", spi_cs_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
